wf_readout_seq: RTL and testbench

- Sequencer for the waterfall IQ sampler's read side (8K x 32b BRAM sampler).
- Runs entirely in the sampler's rd_clk domain. Handles one capture/readout transaction per command:
  - starts a capture, or skips it in continuous mode;
  - waits for capture complete;
  - issues rd_sync with the look-ahead offset;
  - streams N samples to a 16-bit valid/ready consumer as I,Q word pairs.
- Sits between the CPU command interface and the sampler's rd_* port.

---
 rtl/wf_pkg.sv | 14 +
 rtl/wf_readout_seq.sv | 140 ++++++++++++++
 tb/tb_wf_readout_seq.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wf_pkg.sv
// Shared state encoding and constants for the waterfall sampler readout sequencer.
package wf_pkg;
   localparam int WF_A_MSB      = 12;
   localparam int WF_CAP_SETTLE = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_SYNC,
      ST_PRIME,
      ST_STREAM_I,
      ST_STREAM_Q
   } wf_state_e;
endpackage

// File: rtl/wf_readout_seq.sv
// Capture/readout sequencer on the sampler rd_clk: capture, sync, prime, then stream I,Q words.
// First word 2 cycles after rd_sync; out_ready=0 freezes the read address so out_data holds.
module wf_readout_seq
   import wf_pkg::*;
#(
   parameter int A_MSB = WF_A_MSB,
   parameter int N_W   = 14
) (
   input  logic             rd_clk,
   input  logic             rd_rst_n,
   input  logic             cmd_go,
   input  logic             cmd_abort,
   input  logic             cfg_continuous,
   input  logic [A_MSB-1:0] cfg_offset,
   input  logic [N_W-1:0]   cfg_nsamp,
   input  logic             cap_done,
   output logic             cap_start,
   output logic             rd_rst,
   output logic             rd_sync,
   output logic             rd_i,
   output logic             rd_q,
   output logic [A_MSB-1:0] rd_offset,
   input  logic [15:0]      rd_iq,
   output logic [15:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   wf_state_e        state_q;
   logic [N_W-1:0]   cnt_q;
   logic [A_MSB-1:0] offset_q;
   logic [2:0]       settle_q;
   logic             cap_start_q;
   logic             rd_rst_q;
   logic             rd_sync_q;
   logic             rd_i_q;
   logic             valid_q;
   logic             busy_q;
   logic             done_q;

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         offset_q    <= '0;
         settle_q    <= '0;
         cap_start_q <= 1'b0;
         rd_rst_q    <= 1'b1;
         rd_sync_q   <= 1'b0;
         rd_i_q      <= 1'b1;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         rd_rst_q    <= 1'b0;
         cap_start_q <= 1'b0;
         rd_sync_q   <= 1'b0;
         done_q      <= 1'b0;
         if (cmd_abort) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            rd_i_q  <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (cmd_go) begin
                     offset_q <= cfg_offset;
                     cnt_q    <= cfg_nsamp;
                     if (cfg_nsamp == '0) begin
                        done_q <= 1'b1;
                     end else if (cfg_continuous) begin
                        state_q   <= ST_SYNC;
                        rd_sync_q <= 1'b1;
                        busy_q    <= 1'b1;
                     end else begin
                        state_q     <= ST_CAPTURE;
                        cap_start_q <= 1'b1;
                        settle_q    <= '0;
                        busy_q      <= 1'b1;
                     end
                  end
               end
               // The cap_start cycle is the first of the blanked cycles; the
               // full flag seen before then may still be the stale one.
               ST_CAPTURE: begin
                  if (settle_q < 3'(WF_CAP_SETTLE)) begin
                     settle_q <= settle_q + 3'd1;
                  end else if (cap_done) begin
                     state_q   <= ST_SYNC;
                     rd_sync_q <= 1'b1;
                  end
               end
               ST_SYNC: state_q <= ST_PRIME;
               ST_PRIME: begin
                  state_q <= ST_STREAM_I;
                  valid_q <= 1'b1;
                  rd_i_q  <= 1'b1;
               end
               ST_STREAM_I: begin
                  if (out_ready) begin
                     state_q <= ST_STREAM_Q;
                     rd_i_q  <= 1'b0;
                  end
               end
               ST_STREAM_Q: begin
                  if (out_ready) begin
                     rd_i_q <= 1'b1;
                     cnt_q  <= cnt_q - N_W'(1);
                     if (cnt_q == N_W'(1)) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= ST_STREAM_I;
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // Abort must silence the stream in its own cycle, so it gates the registered valid.
   assign out_valid = valid_q & ~cmd_abort;
   assign rd_q      = (state_q == ST_STREAM_Q) & out_ready & ~cmd_abort;
   assign out_data  = rd_iq;
   assign cap_start = cap_start_q;
   assign rd_rst    = rd_rst_q;
   assign rd_sync   = rd_sync_q;
   assign rd_i      = rd_i_q;
   assign rd_offset = offset_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_wf_readout_seq.sv
// Bench for wf_readout_seq with a behavioural sampler read port and a word scoreboard.
module tb_wf_readout_seq;

   logic        rd_clk = 1'b0;
   logic        rd_rst_n;
   logic        cmd_go, cmd_abort, cfg_continuous;
   logic [11:0] cfg_offset;
   logic [13:0] cfg_nsamp;
   logic        cap_done;
   logic        cap_start, rd_rst, rd_sync, rd_i, rd_q;
   logic [11:0] rd_offset;
   logic [15:0] rd_iq, out_data;
   logic        out_valid, out_ready, busy, done;

   always #5 rd_clk = ~rd_clk;

   wf_readout_seq #(.A_MSB(12), .N_W(14)) dut (
      .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .cmd_go(cmd_go), .cmd_abort(cmd_abort),
      .cfg_continuous(cfg_continuous), .cfg_offset(cfg_offset), .cfg_nsamp(cfg_nsamp),
      .cap_done(cap_done), .cap_start(cap_start), .rd_rst(rd_rst), .rd_sync(rd_sync),
      .rd_i(rd_i), .rd_q(rd_q), .rd_offset(rd_offset), .rd_iq(rd_iq), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
   );

   // Sampler read side: address loads wr_addr+offset on rd_sync, steps on rd_q, BRAM data registered.
   logic [12:0] wr_addr, sa_q, sa_d;
   logic [31:0] sdat_q;

   function automatic logic [31:0] mem_word(input logic [12:0] a);
      return {3'b100, a, 3'b010, a};
   endfunction

   always_comb begin
      sa_d = sa_q;
      if (rd_rst)       sa_d = 13'd0;
      else if (rd_sync) sa_d = wr_addr + {1'b0, rd_offset};
      else if (rd_q)    sa_d = sa_q + 13'd1;
   end

   always @(posedge rd_clk) begin
      sa_q   <= sa_d;
      sdat_q <= mem_word(sa_d);
   end

   assign rd_iq = rd_i ? sdat_q[31:16] : sdat_q[15:0];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   logic [15:0] exp_q[$];

   task automatic push_exp(input logic [12:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         logic [12:0] a;
         a = base + 13'(k);
         exp_q.push_back({3'b100, a});
         exp_q.push_back({3'b010, a});
      end
   endtask

   // Monitor: scoreboard pops on handshakes, plus event counters and timestamps.
   int cyc = 0;
   always @(posedge rd_clk) cyc <= cyc + 1;

   int n_cap = 0, n_sync = 0, n_done = 0, n_rdq = 0, n_words = 0, n_valid = 0;
   int n_rdq_bad = 0, n_unstable = 0, n_stall = 0;
   int cap_cyc = 0, sync_cyc = 0, done_cyc = 0, hs_cyc = 0, rise_cyc = 0;
   logic        prev_stall = 1'b0, prev_valid = 1'b0;
   logic [15:0] prev_data = '0;

   always @(negedge rd_clk) begin
      if (cap_start) begin n_cap++;  cap_cyc  = cyc; end
      if (rd_sync)   begin n_sync++; sync_cyc = cyc; end
      if (done)      begin n_done++; done_cyc = cyc; end
      if (rd_q) n_rdq++;
      if (rd_q && !(out_valid && out_ready && !rd_i)) n_rdq_bad++;
      if (out_valid) n_valid++;
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (out_valid && !out_ready) n_stall++;
      if (prev_stall && out_valid && out_data !== prev_data) n_unstable++;
      if (out_valid && out_ready) begin
         n_words++;
         hs_cyc = cyc;
         if (exp_q.size() == 0) chk("sb_unexpected_word", {16'h0, out_data}, 32'hFFFF_FFFF);
         else                   chk("sb_word", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_data  = out_data;
   end

   task automatic go(input logic cont, input logic [11:0] off, input logic [13:0] ns);
      @(posedge rd_clk); #1;
      cfg_continuous = cont;
      cfg_offset     = off;
      cfg_nsamp      = ns;
      cmd_go         = 1'b1;
      @(posedge rd_clk); #1;
      cmd_go = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget, input bit use_pat);
      int d0, k;
      logic [5:0] pat;
      pat = 6'b101001;
      d0  = n_done;
      k   = 0;
      while (n_done == d0 && k < budget) begin
         @(posedge rd_clk); #1;
         k++;
         if (use_pat) out_ready = pat[k % 6];
      end
      chk(nm, (n_done != d0), 1);
   endtask

   int s_cap, s_sync, s_done, s_rdq, s_words, s_valid, s_bad, s_unst, s_stall;

   task automatic snap();
      s_cap = n_cap; s_sync = n_sync; s_done = n_done; s_rdq = n_rdq; s_words = n_words;
      s_valid = n_valid; s_bad = n_rdq_bad; s_unst = n_unstable; s_stall = n_stall;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rd_rst_n = 1'b0; cmd_go = 1'b0; cmd_abort = 1'b0; cfg_continuous = 1'b0;
      cfg_offset = '0; cfg_nsamp = '0; cap_done = 1'b0; out_ready = 1'b1; wr_addr = '0;

      // Reset values
      repeat (3) @(posedge rd_clk);
      @(negedge rd_clk);
      chk("rst_busy", busy, 0);       chk("rst_rd_rst", rd_rst, 1);
      chk("rst_rd_i", rd_i, 1);       chk("rst_offset", rd_offset, 0);
      chk("rst_valid", out_valid, 0); chk("rst_cap_start", cap_start, 0);
      chk("rst_rd_sync", rd_sync, 0); chk("rst_done", done, 0);
      chk("rst_rd_q", rd_q, 0);
      @(posedge rd_clk); #1 rd_rst_n = 1'b1;
      @(negedge rd_clk); chk("rd_rst_first_idle", rd_rst, 1);
      @(negedge rd_clk); chk("rd_rst_after_idle", rd_rst, 0);

      // Continuous, offset 0x100, nsamp 3, always ready
      snap(); wr_addr = 13'h0040; out_ready = 1'b1;
      push_exp(13'h0140, 3);
      go(1'b1, 12'h100, 14'd3);
      chk("cont_offset", rd_offset, 12'h100);
      chk("cont_busy", busy, 1);
      wait_done("cont_done_seen", 50, 1'b0);
      chk("cont_sync_cnt", n_sync - s_sync, 1);
      chk("cont_cap_cnt", n_cap - s_cap, 0);
      chk("cont_rdq_cnt", n_rdq - s_rdq, 3);
      chk("cont_words", n_words - s_words, 6);
      chk("cont_valid_cycles", n_valid - s_valid, 6);
      chk("cont_prime_gap", rise_cyc - sync_cyc, 2);
      chk("cont_done_timing", done_cyc - hs_cyc, 1);
      chk("cont_done_cnt", n_done - s_done, 1);
      chk("cont_sb_empty", exp_q.size(), 0);

      // Capture mode with a stale full flag already high
      snap(); wr_addr = 13'h0100; cap_done = 1'b1;
      push_exp(13'h0110, 1);
      go(1'b0, 12'h010, 14'd1);
      wait_done("cap_done_seen", 50, 1'b0);
      chk("cap_start_cnt", n_cap - s_cap, 1);
      chk("cap_sync_cnt", n_sync - s_sync, 1);
      chk("cap_settle_gap", sync_cyc - cap_cyc, 5);
      chk("cap_words", n_words - s_words, 2);
      cap_done = 1'b0;

      // Capture mode, full flag arrives late
      snap(); wr_addr = 13'h0200;
      push_exp(13'h0200, 1);
      go(1'b0, 12'h000, 14'd1);
      repeat (8) @(posedge rd_clk);
      #1 cap_done = 1'b1;
      wait_done("late_done_seen", 50, 1'b0);
      chk("late_sync_gap", sync_cyc - cap_cyc, 9);
      chk("late_words", n_words - s_words, 2);
      cap_done = 1'b0;

      // Backpressure, nsamp 2
      snap(); wr_addr = 13'h0200; out_ready = 1'b1;
      push_exp(13'h0200, 2);
      go(1'b1, 12'h000, 14'd2);
      wait_done("bp_done_seen", 100, 1'b1);
      chk("bp_words", n_words - s_words, 4);
      chk("bp_rdq_cnt", n_rdq - s_rdq, 2);
      chk("bp_rdq_illegal", n_rdq_bad - s_bad, 0);
      chk("bp_unstable", n_unstable - s_unst, 0);
      chk("bp_stalled", (n_stall - s_stall) > 0, 1);
      chk("bp_sb_empty", exp_q.size(), 0);
      out_ready = 1'b1;

      // Wrap past the top of the buffer
      snap(); wr_addr = 13'h1FFE;
      push_exp(13'h1FFE, 4);
      go(1'b1, 12'h000, 14'd4);
      wait_done("wrap_done_seen", 60, 1'b0);
      chk("wrap_words", n_words - s_words, 8);
      chk("wrap_sb_empty", exp_q.size(), 0);

      // Abort in STREAM_Q with out_ready low
      snap(); wr_addr = 13'h0300; out_ready = 1'b0;
      exp_q.push_back({3'b100, 13'h0304});
      go(1'b1, 12'h004, 14'd2);
      for (int k = 0; k < 20 && !out_valid; k++) begin
         @(posedge rd_clk); #1;
      end
      chk("abort_reach_valid", out_valid, 1);
      out_ready = 1'b1;
      @(posedge rd_clk); #1 out_ready = 1'b0;
      chk("abort_in_q_phase", rd_i, 0);
      cmd_abort = 1'b1; #1;
      chk("abort_valid_now", out_valid, 0);
      chk("abort_rdq_now", rd_q, 0);
      @(posedge rd_clk); #1 cmd_abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_valid_after", out_valid, 0);
      repeat (3) @(posedge rd_clk);
      chk("abort_no_done", n_done - s_done, 0);
      chk("abort_sb_empty", exp_q.size(), 0);

      snap(); wr_addr = 13'h0050; out_ready = 1'b1;
      push_exp(13'h0051, 1);
      go(1'b1, 12'h001, 14'd1);
      wait_done("restart_done_seen", 50, 1'b0);
      chk("restart_words", n_words - s_words, 2);
      chk("restart_sync_cnt", n_sync - s_sync, 1);

      // nsamp = 0
      snap();
      go(1'b0, 12'h00A, 14'd0);
      chk("zero_done_pulse", done, 1);
      chk("zero_busy", busy, 0);
      repeat (3) @(posedge rd_clk);
      chk("zero_no_cap", n_cap - s_cap, 0);
      chk("zero_no_sync", n_sync - s_sync, 0);
      chk("zero_done_cnt", n_done - s_done, 1);

      // go and abort together: abort wins
      snap();
      @(posedge rd_clk); #1;
      cfg_continuous = 1'b1; cfg_nsamp = 14'd3; cmd_go = 1'b1; cmd_abort = 1'b1;
      @(posedge rd_clk); #1 cmd_go = 1'b0; cmd_abort = 1'b0;
      chk("goabort_busy", busy, 0);
      repeat (3) @(posedge rd_clk);
      chk("goabort_no_sync", n_sync - s_sync, 0);

      // cmd_go while busy is ignored
      snap(); wr_addr = 13'h0010; out_ready = 1'b0;
      push_exp(13'h0030, 2);
      go(1'b1, 12'h020, 14'd2);
      repeat (3) @(posedge rd_clk);
      go(1'b0, 12'h555, 14'd5);
      chk("busygo_offset", rd_offset, 12'h020);
      chk("busygo_busy", busy, 1);
      chk("busygo_no_cap", n_cap - s_cap, 0);
      out_ready = 1'b1;
      wait_done("busygo_done_seen", 50, 1'b0);
      repeat (4) @(posedge rd_clk);
      chk("busygo_words", n_words - s_words, 4);
      chk("busygo_done_cnt", n_done - s_done, 1);
      chk("busygo_sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
